hart_run_ctrl: RTL and testbench
================================

// Module: hart_run_ctrl
// PURPOSE
//  Run-state controller for the single-issue core: sequences reset release, normal execution, halt and
//  error states. Gates the PC write enable and latches trap cause/PC for the display path.
//  Adds debug halt, resume and single-step. Sits beside PC/CPU in the FPGA top level, clocked by the PLL clock.
// PARAMETERS
//  DATA_WIDTH   64  PC and instret counter width
//  EXC_WIDTH    8   exception vector width; bit0-2 = fault, bit3 = ECALL, bit4 = EBREAK, bit7 = watchdog
//  BOOT_CYCLES  4   cycles held in BOOT after reset release before fetch starts (>=1)
//  WDT_CYCLES   1024  watchdog limit, used only with HART_WDT_EN
// PORTS
//  clk_i           in   1           core clock (PLL output)
//  rst_i           in   1           reset, asynchronous, active-high (drive with ~lock | ~rst)
//  exceptions_i    in   EXC_WIDTH   exception flags of the instruction committing this cycle
//  commit_valid_i  in   1           one instruction retires this cycle
//  commit_pc_i     in   DATA_WIDTH  PC of the retiring instruction
//  halt_req_i      in   1           debug halt request, level-sensitive
//  resume_i        in   1           pulse: leave HALT toward RUN
//  step_i          in   1           pulse: in HALT, execute exactly one instruction, then re-halt
//  pc_we_o         out  1           PC register write enable
//  state_o         out  3           encoded run state (run_state_e)
//  cause_o         out  EXC_WIDTH   latched exception vector of the last trap
//  trap_pc_o       out  DATA_WIDTH  commit PC that caused the last trap
//  instret_o       out  DATA_WIDTH  retired-instruction counter
// BEHAVIOUR
//  Reset values: state = BOOT, pc_we_o = 0, cause_o = 0, trap_pc_o = 0, instret_o = 0, boot counter = 0.
//  States:
//   BOOT: count BOOT_CYCLES cycles, then go to RUN.
//   RUN:  pc_we_o = 1.
//   HALT: pc_we_o = 0.
//   STEP: pc_we_o = 1 until the first commit_valid_i, then go to HALT.
//   ERROR: pc_we_o = 0; sticky, left only by rst_i.
//  Priority in RUN/STEP with commit_valid_i = 1:
//   1. |exceptions_i[2:0] -> ERROR.
//   2. exceptions_i[3] or [4] -> HALT.
//   3. halt_req_i -> HALT.
//   4. Otherwise RUN (or HALT from STEP).
//  halt_req_i with commit_valid_i = 0 -> HALT; no instruction is lost, PC is held from the next cycle.
//  Trap entry (ERROR or ECALL/EBREAK HALT): cause_o <= exceptions_i and trap_pc_o <= commit_pc_i,
//  registered, visible the cycle after commit. A debug halt does not update cause_o.
//  Exceptions are ignored unless commit_valid_i = 1 and state is RUN or STEP.
//  HALT exits:
//   step_i -> STEP; resume_i -> RUN.
//   Both asserted the same cycle: step wins.
//   resume_i while halt_req_i is still high: stay in HALT.
//   cause_o is cleared on resume and kept on step.
//  instret_o increments on every commit_valid_i in RUN/STEP, including the trapping instruction.
//  instret_o wraps modulo 2^DATA_WIDTH.
//  pc_we_o is combinational from the current state only (no input-to-output path). Zero-latency gate.
//  Reset mid-operation clears all state asynchronously; the first RUN cycle is BOOT_CYCLES cycles after deassertion.
// CONFIGURATION
//  HART_WDT_EN defined:
//   Counter clears on commit_valid_i and increments in RUN/STEP.
//   Reaching WDT_CYCLES -> ERROR with cause_o[7] = 1 and trap_pc_o = last commit PC.
//   Counter holds in other states.
//  HART_WDT_EN undefined: no counter is instantiated and cause_o[7] is always 0.
// STRUCTURE
//  hart_pkg: run_state_e {BOOT, RUN, HALT, STEP, ERROR}, exception bit index localparams
//  (EXC_FAULT_MSB = 2, EXC_ECALL = 3, EXC_EBREAK = 4, EXC_WDT = 7).
//  One sub-module, hart_wdt: the watchdog counter, instantiated only under HART_WDT_EN.
//  The FSM, trap latch and instret counter stay in hart_run_ctrl.
// TESTING
//  1. Reset release, BOOT_CYCLES = 4, no exceptions -> pc_we_o rises exactly 4 cycles after rst_i falls;
//     instret_o counts commits.
//  2. Commit with exceptions_i = 8'h10 at PC 0x80000010 -> state HALT, cause_o = 8'h10,
//     trap_pc_o = 0x80000010, pc_we_o = 0 next cycle.
//  3. exceptions_i = 8'h0A (fault + ECALL) -> ERROR; resume_i has no effect; only rst_i returns the core to BOOT.
//  4. halt_req_i pulse, then step_i with a commit 3 cycles later -> exactly one instret increment;
//     back to HALT; then resume_i -> RUN.
//  5. Halt in RUN with step_i and resume_i in the same cycle -> STEP is taken.
//     rst_i asserted during STEP -> immediate BOOT, outputs reset.
//  6. With HART_WDT_EN, WDT_CYCLES = 16, RUN with no commits -> ERROR after 16 cycles, cause_o = 8'h80.
//     Without the macro, no transition.

Source files
------------

// File: rtl/hart_pkg.sv
// Shared types for the hart run-state controller: run-state encoding and exception bit positions.
package hart_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        RUN   = 3'd1,
        HALT  = 3'd2,
        STEP  = 3'd3,
        ERROR = 3'd4
    } run_state_e;

    localparam int unsigned EXC_FAULT_MSB = 2;
    localparam int unsigned EXC_ECALL     = 3;
    localparam int unsigned EXC_EBREAK    = 4;
    localparam int unsigned EXC_WDT       = 7;

endpackage

// File: rtl/hart_run_ctrl_if.sv
// Commit/debug request and run-state status bundle between the core and its run controller.
interface hart_run_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned EXC_WIDTH  = 8
);
    logic [EXC_WIDTH-1:0]  exceptions_i;
    logic                  commit_valid_i;
    logic [DATA_WIDTH-1:0] commit_pc_i;
    logic                  halt_req_i;
    logic                  resume_i;
    logic                  step_i;
    logic                  pc_we_o;
    logic [2:0]            state_o;
    logic [EXC_WIDTH-1:0]  cause_o;
    logic [DATA_WIDTH-1:0] trap_pc_o;
    logic [DATA_WIDTH-1:0] instret_o;

    modport master (
        output exceptions_i, commit_valid_i, commit_pc_i, halt_req_i, resume_i, step_i,
        input  pc_we_o, state_o, cause_o, trap_pc_o, instret_o
    );

    modport slave (
        input  exceptions_i, commit_valid_i, commit_pc_i, halt_req_i, resume_i, step_i,
        output pc_we_o, state_o, cause_o, trap_pc_o, instret_o
    );
endinterface

// File: rtl/hart_wdt.sv
// Commit watchdog: flags when WDT_CYCLES active cycles pass without a retirement.
// Only compiled when HART_WDT_EN is defined.
`ifdef HART_WDT_EN
module hart_wdt #(
    parameter int unsigned WDT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active_i,
    input  logic clear_i,
    output logic expire_o
);
    localparam int unsigned CNT_W = $clog2(WDT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires during the last idle active cycle so the FSM enters ERROR on the limit edge.
    assign expire_o = active_i && !clear_i && (cnt_q == CNT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule
`endif

// File: rtl/hart_run_ctrl.sv
// Run-state controller: boot sequencing, PC write gating, trap latch, instret and debug halt/step.
// Optional commit watchdog enabled by defining HART_WDT_EN.
module hart_run_ctrl
    import hart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned EXC_WIDTH   = 8,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned WDT_CYCLES  = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    hart_run_ctrl_if.slave  bus
);
    localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);

    run_state_e            state_q, state_d;
    logic [BOOT_W-1:0]     boot_cnt_q, boot_cnt_d;
    logic [EXC_WIDTH-1:0]  cause_q, cause_d;
    logic [DATA_WIDTH-1:0] trap_pc_q, trap_pc_d;
    logic [DATA_WIDTH-1:0] instret_q, instret_d;
    logic [EXC_WIDTH-1:0]  exc;
    logic                  active;
    logic                  fault;
    logic                  halt_trap;
    logic                  wdt_expire;
    logic [DATA_WIDTH-1:0] wdt_pc;
    logic                  pc_we_c;

    // The watchdog cause bit is owned by the internal counter, never by the committing instruction.
    assign exc       = bus.exceptions_i & ~(EXC_WIDTH'(1) << EXC_WDT);
    assign active    = (state_q == RUN) || (state_q == STEP);
    assign fault     = |exc[EXC_FAULT_MSB:0];
    assign halt_trap = exc[EXC_ECALL] | exc[EXC_EBREAK];

`ifdef HART_WDT_EN
    logic [DATA_WIDTH-1:0] last_pc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   last_pc_q <= '0;
        else if (bus.commit_valid_i) last_pc_q <= bus.commit_pc_i;
    end

    assign wdt_pc = last_pc_q;

    hart_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .active_i (active),
        .clear_i  (bus.commit_valid_i),
        .expire_o (wdt_expire)
    );
`else
    logic unused_wdt;
    assign unused_wdt = ^32'(WDT_CYCLES);
    assign wdt_pc     = trap_pc_q;
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        cause_d    = cause_q;
        trap_pc_d  = trap_pc_q;
        instret_d  = instret_q;
        pc_we_c    = 1'b0;

        unique case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
                    state_d    = RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end
            RUN, STEP: begin
                pc_we_c = 1'b1;
                if (bus.commit_valid_i) begin
                    instret_d = instret_q + DATA_WIDTH'(1);
                    if (fault || halt_trap) begin
                        state_d   = fault ? ERROR : HALT;
                        cause_d   = exc;
                        trap_pc_d = bus.commit_pc_i;
                    end else if (bus.halt_req_i || (state_q == STEP)) begin
                        state_d = HALT;
                    end
                end else if (wdt_expire) begin
                    state_d   = ERROR;
                    cause_d   = EXC_WIDTH'(1) << EXC_WDT;
                    trap_pc_d = wdt_pc;
                end else if (bus.halt_req_i) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (bus.step_i) begin
                    state_d = STEP;
                end else if (bus.resume_i && !bus.halt_req_i) begin
                    state_d = RUN;
                    cause_d = '0;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            cause_q    <= '0;
            trap_pc_q  <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            cause_q    <= cause_d;
            trap_pc_q  <= trap_pc_d;
            instret_q  <= instret_d;
        end
    end

    assign bus.pc_we_o   = pc_we_c;
    assign bus.state_o   = state_q;
    assign bus.cause_o   = cause_q;
    assign bus.trap_pc_o = trap_pc_q;
    assign bus.instret_o = instret_q;
endmodule

// File: tb/tb_hart_run_ctrl.sv
// Directed self-checking bench for hart_run_ctrl (BOOT_CYCLES = 4, WDT_CYCLES = 16).
module tb_hart_run_ctrl;
    import hart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    hart_run_ctrl_if #(.DATA_WIDTH(64), .EXC_WIDTH(8)) bus ();

    hart_run_ctrl #(
        .DATA_WIDTH  (64),
        .EXC_WIDTH   (8),
        .BOOT_CYCLES (4),
        .WDT_CYCLES  (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic commit(input logic [63:0] pc, input logic [7:0] exc);
        bus.commit_valid_i = 1'b1;
        bus.commit_pc_i    = pc;
        bus.exceptions_i   = exc;
        tick();
        bus.commit_valid_i = 1'b0;
        bus.exceptions_i   = 8'h00;
    endtask

    task automatic boot_release();
        tick();
        rst = 1'b0;
        tick(3);
        check("boot_hold_state", 64'(bus.state_o), 64'(BOOT));
        check("boot_hold_pcwe", 64'(bus.pc_we_o), 64'd0);
        tick();
        check("boot_run_state", 64'(bus.state_o), 64'(RUN));
        check("boot_run_pcwe", 64'(bus.pc_we_o), 64'd1);
    endtask

    task automatic pulse(input int which);
        if (which == 0) bus.resume_i = 1'b1;
        else            bus.step_i   = 1'b1;
        tick();
        bus.resume_i = 1'b0;
        bus.step_i   = 1'b0;
    endtask

    initial begin
        bus.exceptions_i   = 8'h00;
        bus.commit_valid_i = 1'b0;
        bus.commit_pc_i    = 64'd0;
        bus.halt_req_i     = 1'b0;
        bus.resume_i       = 1'b0;
        bus.step_i         = 1'b0;

        // Reset values, boot delay, commit counting.
        tick(2);
        check("rst_state", 64'(bus.state_o), 64'(BOOT));
        check("rst_pcwe", 64'(bus.pc_we_o), 64'd0);
        check("rst_cause", 64'(bus.cause_o), 64'd0);
        check("rst_trap_pc", bus.trap_pc_o, 64'd0);
        check("rst_instret", bus.instret_o, 64'd0);
        boot_release();
        commit(64'h100, 8'h00);
        commit(64'h104, 8'h00);
        commit(64'h108, 8'h00);
        tick();
        check("run_instret3", bus.instret_o, 64'd3);
        check("run_state", 64'(bus.state_o), 64'(RUN));

        // EBREAK halts and latches cause/PC; resume clears cause.
        commit(64'h8000_0010, 8'h10);
        check("ebreak_state", 64'(bus.state_o), 64'(HALT));
        check("ebreak_cause", 64'(bus.cause_o), 64'h10);
        check("ebreak_trap_pc", bus.trap_pc_o, 64'h8000_0010);
        check("ebreak_pcwe", 64'(bus.pc_we_o), 64'd0);
        check("ebreak_instret", bus.instret_o, 64'd4);
        pulse(0);
        check("resume_state", 64'(bus.state_o), 64'(RUN));
        check("resume_cause_clr", 64'(bus.cause_o), 64'd0);
        check("resume_trap_pc_kept", bus.trap_pc_o, 64'h8000_0010);

        // Incoming bit 7 is not a trap source and never reaches cause.
        commit(64'h120, 8'h80);
        check("bit7_state", 64'(bus.state_o), 64'(RUN));
        check("bit7_cause", 64'(bus.cause_o), 64'd0);
        check("bit7_instret", bus.instret_o, 64'd5);

        // Debug halt, single step with a late commit, resume.
        bus.halt_req_i = 1'b1;
        tick();
        bus.halt_req_i = 1'b0;
        check("dbg_halt_state", 64'(bus.state_o), 64'(HALT));
        check("dbg_halt_pcwe", 64'(bus.pc_we_o), 64'd0);
        pulse(1);
        check("step_state", 64'(bus.state_o), 64'(STEP));
        check("step_pcwe", 64'(bus.pc_we_o), 64'd1);
        tick(2);
        check("step_wait_state", 64'(bus.state_o), 64'(STEP));
        check("step_wait_instret", bus.instret_o, 64'd5);
        commit(64'h200, 8'h00);
        check("step_rehalt", 64'(bus.state_o), 64'(HALT));
        check("step_instret", bus.instret_o, 64'd6);
        check("step_cause", 64'(bus.cause_o), 64'd0);
        bus.halt_req_i = 1'b1;
        pulse(0);
        check("resume_blocked", 64'(bus.state_o), 64'(HALT));
        bus.halt_req_i = 1'b0;
        pulse(0);
        check("resume_run", 64'(bus.state_o), 64'(RUN));

        // ECALL halt, step beats resume, cause kept; reset during STEP.
        commit(64'h300, 8'h08);
        check("ecall_state", 64'(bus.state_o), 64'(HALT));
        check("ecall_cause", 64'(bus.cause_o), 64'h08);
        bus.step_i   = 1'b1;
        bus.resume_i = 1'b1;
        tick();
        bus.step_i   = 1'b0;
        bus.resume_i = 1'b0;
        check("step_wins", 64'(bus.state_o), 64'(STEP));
        check("step_cause_kept", 64'(bus.cause_o), 64'h08);
        check("ecall_instret", bus.instret_o, 64'd7);
        rst = 1'b1;
        #1;
        check("async_rst_state", 64'(bus.state_o), 64'(BOOT));
        check("async_rst_pcwe", 64'(bus.pc_we_o), 64'd0);
        check("async_rst_cause", 64'(bus.cause_o), 64'd0);
        check("async_rst_trap_pc", bus.trap_pc_o, 64'd0);
        check("async_rst_instret", bus.instret_o, 64'd0);
        boot_release();

        // Watchdog: 16 idle RUN cycles after the last commit.
        commit(64'h400, 8'h00);
        tick(15);
        check("wdt_before", 64'(bus.state_o), 64'(RUN));
        tick();
`ifdef HART_WDT_EN
        check("wdt_state", 64'(bus.state_o), 64'(ERROR));
        check("wdt_cause", 64'(bus.cause_o), 64'h80);
        check("wdt_trap_pc", bus.trap_pc_o, 64'h400);
        rst = 1'b1;
        boot_release();
`else
        check("nowdt_state", 64'(bus.state_o), 64'(RUN));
        check("nowdt_cause", 64'(bus.cause_o), 64'd0);
`endif

        // Fault with ECALL: fault wins, ERROR is sticky until reset.
        commit(64'h500, 8'h0A);
        check("fault_state", 64'(bus.state_o), 64'(ERROR));
        check("fault_cause", 64'(bus.cause_o), 64'h0A);
        check("fault_trap_pc", bus.trap_pc_o, 64'h500);
        check("fault_pcwe", 64'(bus.pc_we_o), 64'd0);
        pulse(0);
        pulse(1);
        check("error_sticky", 64'(bus.state_o), 64'(ERROR));
        check("error_cause_kept", 64'(bus.cause_o), 64'h0A);
        rst = 1'b1;
        tick();
        check("error_rst_state", 64'(bus.state_o), 64'(BOOT));
        check("error_rst_cause", 64'(bus.cause_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
